// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan gate-lab checkers.
// Holds the sweep FSM encoding, vector width and golden-mode codes.
package demorgan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int VEC_W = 2;

   localparam logic MODE_NAND = 1'b0;
   localparam logic MODE_NOR  = 1'b1;

endpackage

// File: rtl/demorgan_sweep_checker_if.sv
// Control, status and gate-under-test signals of the sweep checker.
// master = controller/environment side, slave = checker side.
interface demorgan_sweep_checker_if
   import demorgan_pkg::*;
#(
   parameter int CNT_W = 8
) ();

   logic             start;
   logic             mode;
   logic             e;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_cnt;
   logic             fail_valid;
   logic [VEC_W-1:0] fail_vec;

   modport master (
      output start,
      output mode,
      output e,
      input  a,
      input  b,
      input  busy,
      input  done,
      input  pass,
      input  err_cnt,
      input  fail_valid,
      input  fail_vec
   );

   modport slave (
      input  start,
      input  mode,
      input  e,
      output a,
      output b,
      output busy,
      output done,
      output pass,
      output err_cnt,
      output fail_valid,
      output fail_vec
   );

endinterface

// File: rtl/demorgan_golden.sv
// Golden De Morgan reference: NAND form ~a|~b or NOR form ~a&~b.
// Purely combinational so other gate-lab checkers can reuse it.
module demorgan_golden
   import demorgan_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic mode,
   output logic exp
);

   always_comb begin
      exp = ~a | ~b;
      if (mode == MODE_NOR) begin
         exp = ~a & ~b;
      end
   end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Clocked exhaustive 2-bit sweep of a De Morgan gate with result capture.
// Each vector is held DWELL cycles and e is sampled SETTLE cycles in.
module demorgan_sweep_checker
   import demorgan_pkg::*;
#(
   parameter int DWELL  = 50,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   demorgan_sweep_checker_if.slave  bus
);

   localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(DWELL - 1);
   localparam logic [DCNT_W-1:0] D_SAMP = DCNT_W'(SETTLE);
   localparam logic [VEC_W-1:0]  V_LAST = '1;

   state_t              state;
   logic [VEC_W-1:0]    vec;
   logic [DCNT_W-1:0]   dcnt;
   logic                mode_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [CNT_W-1:0]    err_q;
   logic                fv_q;
   logic [VEC_W-1:0]    fvec_q;

   logic                exp_v;
   logic                smp;
   logic                miss;

   demorgan_golden u_golden (
      .a    (vec[0]),
      .b    (vec[1]),
      .mode (mode_q),
      .exp  (exp_v)
   );

   assign smp  = (state == RUN) && (dcnt == D_SAMP);
   assign miss = smp && (bus.e != exp_v);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         vec    <= '0;
         dcnt   <= '0;
         mode_q <= MODE_NAND;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= '0;
         fv_q   <= 1'b0;
         fvec_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state  <= RUN;
                  vec    <= '0;
                  dcnt   <= '0;
                  mode_q <= bus.mode;
                  busy_q <= 1'b1;
                  pass_q <= 1'b0;
                  err_q  <= '0;
                  fv_q   <= 1'b0;
                  fvec_q <= '0;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               if (miss) begin
                  if (err_q != '1) begin
                     err_q <= err_q + 1'b1;
                  end
                  if (!fv_q) begin
                     fv_q   <= 1'b1;
                     fvec_q <= vec;
                  end
               end
               if (dcnt != D_LAST) begin
                  dcnt <= dcnt + 1'b1;
               end else begin
                  dcnt <= '0;
                  if (vec == V_LAST) begin
                     // a sample on this very edge must still veto pass
                     state  <= DONE;
                     vec    <= '0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     pass_q <= (err_q == '0) && !miss;
                  end else begin
                     vec <= vec + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.a          = vec[0];
   assign bus.b          = vec[1];
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_cnt    = err_q;
   assign bus.fail_valid = fv_q;
   assign bus.fail_vec   = fvec_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboard bench: sweeps push expected results, monitors pop on done.
// A second instance with a 1-bit counter covers saturation.
module tb_demorgan_sweep_checker;

   localparam int DW  = 50;
   localparam int DW2 = 2;

   typedef struct {
      logic       pass;
      logic [7:0] err;
      logic       fv;
      logic [1:0] fvec;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [1:0] gsel;
   int         cyc;
   int         n_cmp;
   int         n_bad;
   int         trk_k;
   bit         trk_on;
   exp_t       q[$];
   exp_t       q2[$];
   exp_t       x_mon;
   exp_t       x_mon2;
   int         rel;

   demorgan_sweep_checker_if #(.CNT_W(8)) bus ();
   demorgan_sweep_checker_if #(.CNT_W(1)) sbus ();

   demorgan_sweep_checker #(
      .DWELL  (DW),
      .SETTLE (2),
      .CNT_W  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   demorgan_sweep_checker #(
      .DWELL  (DW2),
      .SETTLE (1),
      .CNT_W  (1)
   ) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   // 0 NAND gate, 1 NOR gate, 2 stuck-at-0, 3 stuck-at-1
   function automatic logic gate_fn(input logic a, input logic b,
                                    input logic [1:0] sel);
      case (sel)
         2'd0:    return ~(a & b);
         2'd1:    return ~(a | b);
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   assign bus.e  = gate_fn(bus.a, bus.b, gsel);
   assign sbus.e = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act,
                        input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a"}, bus.a, 0);
      check({tag, "_b"}, bus.b, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_pass"}, bus.pass, 0);
      check({tag, "_err"}, bus.err_cnt, 0);
      check({tag, "_fv"}, bus.fail_valid, 0);
      check({tag, "_fvec"}, bus.fail_vec, 0);
   endtask

   always @(negedge clk) begin
      if (bus.done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            x_mon = q.pop_front();
            check("done_cycle", cyc, x_mon.cyc);
            check("pass", bus.pass, x_mon.pass);
            check("err_cnt", bus.err_cnt, x_mon.err);
            check("fail_valid", bus.fail_valid, x_mon.fv);
            check("fail_vec", bus.fail_vec, x_mon.fvec);
            check("busy_at_done", bus.busy, 0);
            check("ab_at_done", {bus.b, bus.a}, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (sbus.done) begin
         if (q2.size() == 0) begin
            check("sat_unexpected_done", 1, 0);
         end else begin
            x_mon2 = q2.pop_front();
            check("sat_done_cycle", cyc, x_mon2.cyc);
            check("sat_pass", sbus.pass, x_mon2.pass);
            check("sat_err_cnt", sbus.err_cnt, x_mon2.err);
            check("sat_fail_valid", sbus.fail_valid, x_mon2.fv);
            check("sat_fail_vec", sbus.fail_vec, x_mon2.fvec);
         end
      end
   end

   // Cycle-accurate waveform model of a, b, busy and done
   always @(negedge clk) begin
      if (trk_on && cyc >= trk_k) begin
         rel = cyc - trk_k;
         check("busy_wave", bus.busy, (rel < 4 * DW) ? 1 : 0);
         check("ab_wave", {bus.b, bus.a}, (rel < 4 * DW) ? rel / DW : 0);
         check("done_wave", bus.done, (rel == 4 * DW) ? 1 : 0);
      end
   end

   task automatic run_sweep(input logic m, input logic [1:0] g,
                            input logic ep, input int eerr,
                            input logic efv, input logic [1:0] evec,
                            input bit hold);
      exp_t x;
      @(negedge clk);
      gsel      = g;
      bus.mode  = m;
      bus.start = 1'b1;
      x = '{ep, 8'(eerr), efv, evec, cyc + 1 + 4 * DW};
      q.push_back(x);
      trk_k  = cyc + 1;
      trk_on = 1'b1;
      if (hold) begin
         while (cyc < trk_k + 4 * DW - 1) @(negedge clk);
      end else begin
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.mode  = ~m;
      while (cyc < trk_k + 4 * DW + 1) @(negedge clk);
      trk_on = 1'b0;
   endtask

   initial begin
      exp_t xs;
      int   k;
      cyc        = 0;
      n_cmp      = 0;
      n_bad      = 0;
      trk_on     = 1'b0;
      trk_k      = 0;
      gsel       = 2'd0;
      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.mode   = 1'b0;
      sbus.start = 1'b0;
      sbus.mode  = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("reset");
      check("sat_reset_err", sbus.err_cnt, 0);
      check("sat_reset_busy", sbus.busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      while (cyc < 8) @(negedge clk);

      // start sampled at edge 10, done after edge 210
      run_sweep(1'b0, 2'd0, 1'b1, 0, 1'b0, 2'd0, 1'b0);
      run_sweep(1'b1, 2'd1, 1'b1, 0, 1'b0, 2'd0, 1'b0);
      run_sweep(1'b1, 2'd0, 1'b0, 2, 1'b1, 2'd1, 1'b0);
      run_sweep(1'b0, 2'd2, 1'b0, 3, 1'b1, 2'd0, 1'b0);
      run_sweep(1'b0, 2'd3, 1'b0, 1, 1'b1, 2'd3, 1'b0);

      @(negedge clk);
      sbus.start = 1'b1;
      xs = '{1'b0, 8'd1, 1'b1, 2'd0, cyc + 1 + 4 * DW2};
      q2.push_back(xs);
      @(negedge clk);
      sbus.start = 1'b0;
      repeat (4 * DW2 + 3) @(negedge clk);

      @(negedge clk);
      gsel      = 2'd0;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      k         = cyc + 1;
      trk_k     = k;
      trk_on    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < k + 119) @(negedge clk);
      trk_on = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("idle_after_rst_busy", bus.busy, 0);
         check("idle_after_rst_ab", {bus.b, bus.a}, 0);
      end

      run_sweep(1'b0, 2'd0, 1'b1, 0, 1'b0, 2'd0, 1'b1);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", q.size(), 0);
      check("sat_scoreboard_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demorgan_sweep_checker.md
# demorgan_sweep_checker

Self-checking stimulus/response stage for the two-input De Morgan gate blocks. It sits directly upstream and downstream of the gate under test: it drives the gate's `a`/`b` inputs through the exhaustive 2-bit sweep and samples the gate's `e` output. It compares each sample against the golden De Morgan form selected by `mode` and reports pass/fail, an error count and the first failing vector. It replaces free-running `always`-toggle stimulus with a clocked, repeatable sweep usable on hardware as well as in simulation.

## Interface
Parameters:
- `DWELL`, default 50: clock cycles each input vector is held. Legal range is `DWELL >= SETTLE+1`.
- `SETTLE`, default 2: cycles after a vector change before `e` is sampled. Must be at least 1.
- `CNT_W`, default 8: width of the error counter.

Ports (reset is asynchronous, active-high):
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep. Sampled only in IDLE or DONE.
- `mode` in 1: golden function. 0 = NAND form, `~a | ~b`. 1 = NOR form, `~a & ~b`. Latched at start.
- `e` in 1: output of the gate under test.
- `a` out 1: stimulus to the gate under test. Equals `vec[0]`, so it toggles every DWELL cycles.
- `b` out 1: stimulus to the gate under test. Equals `vec[1]`, so it toggles every 2*DWELL cycles.
- `busy` out 1: high while a sweep is running.
- `done` out 1: one-cycle pulse when the sweep completes.
- `pass` out 1: high when the last sweep had zero mismatches. Held until the next start.
- `err_cnt` out CNT_W: number of mismatches in the current or last sweep. Saturating.
- `fail_valid` out 1: high once any mismatch has been recorded in the current or last sweep.
- `fail_vec` out 2: `{b,a}` of the first mismatching vector.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE after the last cycle of vector 3.
  - DONE → IDLE on the next cycle. If `start`=1 in DONE, go directly to RUN.
- Entry into RUN does the following on the same edge:
  - Sets `vec`=0 and `dcnt`=0.
  - Clears `err_cnt`, `fail_valid`, `fail_vec` and `pass`.
  - Latches `mode`.
- In RUN, `dcnt` counts 0..DWELL-1.
  - At `dcnt`==DWELL-1, `dcnt` wraps to 0 and `vec` increments.
  - At `vec`==3 with `dcnt`==DWELL-1, the FSM goes to DONE instead of incrementing.
- Vector order for `{b,a}` is 00, 01, 10, 11.
- Sampling happens at `dcnt`==SETTLE.
  - `exp` = NAND or NOR of the current a and b, per the latched mode.
  - If `e` != `exp`, `err_cnt` increments, saturating at 2^CNT_W-1.
  - If `fail_valid` is 0 at that point, `fail_vec` captures `vec` and `fail_valid` is set.
- On entering DONE:
  - `pass` = (`err_cnt`==0), including any mismatch from the final sample.
  - `a` and `b` return to 0.
- `start` during RUN is ignored. `mode` changes during RUN are ignored.
- `e` is X/Z-intolerant only at sample points. Between samples it is don't-care.

## Timing
- Reset value of every output is 0: `a`, `b`, `busy`, `done`, `pass`, `err_cnt`, `fail_valid`, `fail_vec`.
- Reset asserted mid-sweep forces IDLE and all zeros immediately, with no clock edge required.
- Let `start` be sampled high at edge k.
  - `busy`=1 and `{b,a}`=00 are visible after edge k.
  - Vector i is driven after edges k+i·DWELL through k+(i+1)·DWELL−1.
  - Sample i is taken at edge k+i·DWELL+SETTLE.
  - After edge k+4·DWELL: `busy`=0, `done`=1 (for that one cycle only), `pass` is valid, and `a`=`b`=0.
- Total sweep length is exactly 4·DWELL cycles. There are no bubbles between vectors.
- All outputs are registered. There is no combinational path from `e` to any output.

## Structure
- Package `demorgan_pkg` contains:
  - The state enum (IDLE, RUN, DONE).
  - `VEC_W`=2.
  - Mode constants `MODE_NAND`=0 and `MODE_NOR`=1.
- Sub-module `demorgan_golden` is purely combinational.
  - Inputs: `a`, `b`, `mode`. Output: `exp`.
  - It is reused by future gate-lab checkers.
- The top level holds the FSM, the `dcnt`/`vec` counters and the result registers.

## Test plan
- **Correct NAND, no errors.** DWELL=50, SETTLE=2, mode=0, `e` from a correct NAND gate, `start` pulsed at edge 10.
  - `a` toggles at edges 60, 110, 160.
  - `b` rises at 110.
  - `done` pulses after edge 210 with `pass`=1, `err_cnt`=0, `fail_valid`=0.
- **Correct NOR, no errors.** mode=1 with a correct NOR gate → `pass`=1, `err_cnt`=0.
- **Wrong golden mode.** mode=1 with a correct NAND gate.
  - Mismatches occur at vectors 01 and 10.
  - Expected result: `err_cnt`=2, `fail_vec`=01, `pass`=0.
- **Stuck-at output.** `e` tied to 0 with mode=0.
  - Expected result: `err_cnt`=3, `fail_vec`=00.
- **Saturation.** CNT_W=1 with `e` stuck at 0 → `err_cnt`=1 (saturated), `pass`=0.
- **Reset and start edge cases.**
  - `rst` pulsed at edge k+120 mid-sweep: all outputs are 0 immediately, and the block stays in IDLE.
  - A later `start` runs a clean sweep with `pass`=1.
  - `start` held high through RUN does not restart the sweep.
